// File: rtl/demux_1to3.sv
// Routes each input word to one of three skid-free output registers, one-cycle latency.
// ready is the "free" status of the port selected by select_i, so a stalled port only blocks words aimed at it.
module demux_1to3 #(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [size-1:0] data_i,
    input  logic [1:0]      select_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [size-1:0] data0_o,
    output logic [size-1:0] data1_o,
    output logic [size-1:0] data2_o,
    output logic            valid0_o,
    output logic            valid1_o,
    output logic            valid2_o,
    input  logic            ready0_i,
    input  logic            ready1_i,
    input  logic            ready2_i,
    output logic [7:0]      count0_o,
    output logic [7:0]      count1_o,
    output logic [7:0]      count2_o
);

    logic [2:0] sel_oh;
    logic [2:0] out_vld;
    logic [2:0] out_rdy;
    logic [2:0] free;
    logic [2:0] load;
    logic [2:0] drain;

    // Codes 10 and 11 both map to port 2.
    assign sel_oh  = select_i[1] ? 3'b100 : (select_i[0] ? 3'b010 : 3'b001);
    assign out_rdy = {ready2_i, ready1_i, ready0_i};
    assign free    = ~out_vld | out_rdy;
    assign ready_o = |(free & sel_oh);
    assign load    = sel_oh & {3{valid_i & ready_o}};
    assign drain   = out_vld & out_rdy;

    for (genvar n = 0; n < 3; n++) begin : g_port
        logic [size-1:0] dat_q;
        logic            vld_q;
        logic [7:0]      cnt_q;

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                dat_q <= '0;
                vld_q <= 1'b0;
                cnt_q <= 8'd0;
            end else begin
                // A load on the draining edge keeps valid high: one word per cycle.
                if (load[n]) begin
                    dat_q <= data_i;
                    vld_q <= 1'b1;
                end else if (drain[n]) begin
                    vld_q <= 1'b0;
                end
                if (drain[n] && cnt_q != 8'hFF) begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    assign out_vld  = {g_port[2].vld_q, g_port[1].vld_q, g_port[0].vld_q};
    assign data0_o  = g_port[0].dat_q;
    assign data1_o  = g_port[1].dat_q;
    assign data2_o  = g_port[2].dat_q;
    assign valid0_o = g_port[0].vld_q;
    assign valid1_o = g_port[1].vld_q;
    assign valid2_o = g_port[2].vld_q;
    assign count0_o = g_port[0].cnt_q;
    assign count1_o = g_port[1].cnt_q;
    assign count2_o = g_port[2].cnt_q;

endmodule

// File: tb/tb_demux_1to3.sv
// Scoreboard bench for demux_1to3: per-port expected-word queues and delivery counters.
module tb_demux_1to3;

    localparam int SIZE = 32;

    logic            clk_i;
    logic            rst_i;
    logic [SIZE-1:0] data_i;
    logic [1:0]      select_i;
    logic            valid_i;
    logic            ready_o;
    logic [SIZE-1:0] data0_o, data1_o, data2_o;
    logic            valid0_o, valid1_o, valid2_o;
    logic            ready0_i, ready1_i, ready2_i;
    logic [7:0]      count0_o, count1_o, count2_o;

    demux_1to3 #(.size(SIZE)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .select_i(select_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .data0_o(data0_o), .data1_o(data1_o), .data2_o(data2_o),
        .valid0_o(valid0_o), .valid1_o(valid1_o), .valid2_o(valid2_o),
        .ready0_i(ready0_i), .ready1_i(ready1_i), .ready2_i(ready2_i),
        .count0_o(count0_o), .count1_o(count1_o), .count2_o(count2_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [SIZE-1:0] q0[$];
    logic [SIZE-1:0] q1[$];
    logic [SIZE-1:0] q2[$];
    int cnt_exp [3];
    int run0 = 0;
    int max0 = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_pop(input int n, input logic [SIZE-1:0] d);
        logic [SIZE-1:0] e;
        int sz;
        sz = (n == 0) ? q0.size() : (n == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
            chk($sformatf("unexpected_word_p%0d", n), {32'd0, d}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
            if (n == 0)      e = q0.pop_front();
            else if (n == 1) e = q1.pop_front();
            else             e = q2.pop_front();
            chk($sformatf("order_p%0d", n), {32'd0, d}, {32'd0, e});
            if (cnt_exp[n] < 255) cnt_exp[n]++;
        end
    endtask

    // Output transfers are observed mid-cycle; they complete on the following rising edge.
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (valid0_o && ready0_i) check_pop(0, data0_o);
            if (valid1_o && ready1_i) check_pop(1, data1_o);
            if (valid2_o && ready2_i) check_pop(2, data2_o);
            if (valid0_o) run0++;
            else          run0 = 0;
            if (run0 > max0) max0 = run0;
        end
    end

    task automatic push_exp(input logic [1:0] sel, input logic [SIZE-1:0] d);
        if (sel == 2'd0)      q0.push_back(d);
        else if (sel == 2'd1) q1.push_back(d);
        else                  q2.push_back(d);
    endtask

    // Present a word and hold it until accepted; returns at rising edge + 1.
    task automatic send(input logic [1:0] sel, input logic [SIZE-1:0] d);
        bit done;
        done     = 1'b0;
        valid_i  = 1'b1;
        select_i = sel;
        data_i   = d;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk_i);
            if (ready_o) begin
                push_exp(sel, d);
                done = 1'b1;
            end
            @(posedge clk_i);
            #1;
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic flush_model();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int i = 0; i < 3; i++) cnt_exp[i] = 0;
    endtask

    task automatic pulse_reset();
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        flush_model();
        @(posedge clk_i);
        #1 rst_i = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0;
        valid_i = 1'b0; select_i = 2'd0; data_i = '0;
        ready0_i = 1'b0; ready1_i = 1'b1; ready2_i = 1'b0;
        flush_model();

        // Reset state, ready high for every select while held in reset.
        #12;
        chk("rst_valid", {valid2_o, valid1_o, valid0_o}, 3'b000);
        chk("rst_data0", data0_o, 0);
        chk("rst_data1", data1_o, 0);
        chk("rst_data2", data2_o, 0);
        chk("rst_counts", {count2_o, count1_o, count0_o}, 0);
        for (int s = 0; s < 4; s++) begin
            valid_i = 1'b1; select_i = s[1:0]; data_i = 32'hFFFF_0000;
            @(posedge clk_i);
            #1 chk($sformatf("rst_ready_sel%0d", s), ready_o, 1'b1);
            chk("rst_no_load", {valid2_o, valid1_o, valid0_o}, 3'b000);
        end
        valid_i = 1'b0;
        rst_i = 1'b1;

        // Basic route.
        send(2'd1, 32'hA5A5_A5A5);
        chk("basic_valid1", valid1_o, 1'b1);
        chk("basic_data1", data1_o, 32'hA5A5_A5A5);
        chk("basic_others", {valid2_o, valid0_o}, 2'b00);
        idle(1);
        chk("basic_count1", count1_o, 8'd1);
        chk("basic_count1_model", count1_o, cnt_exp[1]);
        chk("basic_data1_hold", data1_o, 32'hA5A5_A5A5);

        // Select changes with valid low leave state alone.
        for (int s = 0; s < 4; s++) begin
            select_i = s[1:0];
            idle(1);
        end
        chk("novalid_nostate", {valid2_o, valid1_o, valid0_o}, 3'b000);

        // Stall and hold, then simultaneous drain and load on port 2.
        send(2'd2, 32'h11);
        valid_i = 1'b1; select_i = 2'd3; data_i = 32'h22;
        repeat (2) begin
            @(negedge clk_i);
            chk("stall_ready", ready_o, 1'b0);
            chk("stall_hold", data2_o, 32'h11);
            @(posedge clk_i);
            #1;
        end
        ready2_i = 1'b1;
        send(2'd3, 32'h22);
        chk("stall_valid2", valid2_o, 1'b1);
        chk("stall_data2", data2_o, 32'h22);
        idle(2);

        // Independence: port 0 stalled, stream on port 1.
        ready0_i = 1'b0;
        send(2'd0, 32'h55);
        for (int i = 0; i < 4; i++) send(2'd1, 32'h100 + i);
        idle(2);
        chk("indep_data0", data0_o, 32'h55);
        chk("indep_valid0", valid0_o, 1'b1);
        chk("indep_q1_empty", q1.size(), 0);
        chk("indep_count1", count1_o, cnt_exp[1]);

        // Throughput on port 0 from a clean reset.
        pulse_reset();
        ready0_i = 1'b1;
        max0 = 0;
        for (int i = 0; i < 10; i++) send(2'd0, 32'hC000 + i);
        idle(3);
        chk("thru_run", max0, 10);
        chk("thru_count0", count0_o, 8'd10);

        // Saturation on port 2.
        ready2_i = 1'b1;
        for (int i = 0; i < 300; i++) send(2'd2, $urandom);
        idle(3);
        chk("sat_count2", count2_o, 8'd255);
        chk("sat_model", count2_o, cnt_exp[2]);

        // Asynchronous reset while port 1 holds a word.
        ready1_i = 1'b1;
        send(2'd1, 32'h1234);
        idle(2);
        ready1_i = 1'b0;
        send(2'd1, 32'hDEAD_BEEF);
        chk("arst_pre_valid1", valid1_o, 1'b1);
        #2 rst_i = 1'b0;
        #1;
        chk("arst_valid1", valid1_o, 1'b0);
        chk("arst_data1", data1_o, 0);
        chk("arst_count1", count1_o, 0);
        flush_model();
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        ready1_i = 1'b1;
        send(2'd1, 32'h77);
        chk("post_rst_valid1", valid1_o, 1'b1);
        chk("post_rst_data1", data1_o, 32'h77);
        idle(3);
        chk("post_rst_count1", count1_o, 8'd1);

        chk("final_q0_empty", q0.size(), 0);
        chk("final_q1_empty", q1.size(), 0);
        chk("final_q2_empty", q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1to3.md
DEMUX_1TO3 -- requirements
Module: demux_1to3

Interface
REQ-001 The block SHALL have parameter size, default 32, giving the data width in bits.
REQ-002 The port list SHALL be, one per line:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset, asynchronous, active-low
- data_i  input  size  source word
- select_i  input  2  destination: 00->port 0, 01->port 1, 10/11->port 2
- valid_i  input  1  source word and select valid
- ready_o  output  1  block accepts word this cycle
- data0_o / data1_o / data2_o  output  size each  destination words
- valid0_o / valid1_o / valid2_o  output  1 each  destination word valid
- ready0_i / ready1_i / ready2_i  input  1 each  destination accepts word
- count0_o / count1_o / count2_o  output  8 each  words delivered per port, saturating

Function
REQ-003 Each destination port SHALL own one output holding register (data, valid).
REQ-004 Input transfer SHALL occur on a rising edge where valid_i=1 and ready_o=1.
REQ-005 Port n SHALL be "free" when valid_n_o=0, or when valid_n_o=1 and ready_n_i=1 in the same cycle.
REQ-006 ready_o SHALL equal "free" of the port decoded from the current select_i; it SHALL NOT depend on valid_i.
REQ-007 On input transfer, the decoded port's register SHALL load data_i and set valid on the same edge: one-cycle latency, input to valid_n_o.
REQ-008 Output transfer on port n SHALL occur on an edge where valid_n_o=1 and ready_n_i=1; valid_n_o SHALL then clear unless a new word for port n is accepted on the same edge.
REQ-009 Simultaneous drain and load of the same port SHALL sustain one word per cycle, with no bubble and no loss.
REQ-010 While valid_n_o=1 and ready_n_i=0, data_n_o SHALL remain stable.
REQ-011 The three ports SHALL operate independently: a stalled port SHALL NOT block words selected to other free ports.
REQ-012 Words selected to the same port SHALL emerge in acceptance order; no ordering is guaranteed across ports.
REQ-013 data_n_o SHALL hold its last value after valid_n_o clears.
REQ-014 count_n_o SHALL increment by 1 on each output transfer on port n and saturate at 255, with no wrap.
REQ-015 select_i=11 SHALL behave exactly as 10, with no error indication.
REQ-016 When valid_i=0, select_i SHALL have no effect on state.

Reset
REQ-017 While rst_i=0, all valid_n_o SHALL be 0, all data_n_o SHALL be 0 and all count_n_o SHALL be 0, regardless of clk_i.
REQ-018 Reset asserted mid-operation SHALL discard held words with no partial delivery.
REQ-019 While rst_i=0, ready_o SHALL be 1 for any select_i, since all ports are empty, but no transfer SHALL be recorded.
REQ-020 The first accept SHALL be possible on the first rising edge after rst_i rises.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Basic route: sel=01, data=0xA5A5A5A5, valid 1 cycle, ready1_i=1 -> next cycle valid1_o=1, data1_o=0xA5A5A5A5; valid0_o and valid2_o stay 0; count1_o=1 after drain.
- Stall/hold: ready2_i=0, send 0x11 sel=10, then present 0x22 sel=11 -> ready_o=0, data2_o stays 0x11; raise ready2_i -> 0x11 transfers, 0x22 accepted same edge, valid2_o stays 1.
- Independence: port 0 stalled holding a word, sel=01 stream of 4 words with ready1_i=1 -> all 4 delivered in order on port 1, data0_o unchanged.
- Throughput: 10 back-to-back words sel=00, ready0_i=1 -> 10 consecutive valid0_o cycles, count0_o=10.
- Saturation: 300 transfers on port 2 -> count2_o=255, no wrap.
- Async reset: assert rst_i=0 between clock edges while valid1_o=1 -> valid1_o, data1_o and count1_o go to 0 immediately; after release, a sel=01 word is delivered after one cycle.
